// File: rtl/shift_cube_pkg.sv
// Shared types and helpers for the shift_cube block.
// Defines the shift mode and the (a,b,c) to logical-position mapping.
package shift_cube_pkg;

  typedef enum logic {
    MODE_BIT  = 1'b0,
    MODE_ELEM = 1'b1
  } mode_e;

  // Position depends only on offsets from the low indices, never on range direction.
  function automatic int cube_pos(input int a, input int b, input int c,
                                  input int a_lo, input int b_lo, input int c_lo,
                                  input int db, input int dc);
    return (((a - a_lo) * db) + (b - b_lo)) * dc + (c - c_lo);
  endfunction

endpackage

// File: rtl/shift_cube_fill_ctr.sv
// Saturating fill counter for shift_cube; tracks how many valid bits are held
// and flags when the whole cube is occupied.
module shift_cube_fill_ctr #(
  parameter int TOTAL = 30,
  parameter int CW    = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          load,
  input  logic          shift,
  input  logic [CW-1:0] step,
  output logic [CW-1:0] fill_count,
  output logic          full
);

  logic [CW:0]   sum;
  logic [CW-1:0] next_count;

  always_comb begin
    sum        = {1'b0, fill_count} + {1'b0, step};
    next_count = fill_count;
    if (clear)
      next_count = '0;
    else if (load)
      next_count = CW'(TOTAL);
    else if (shift) begin
      if (sum >= (CW+1)'(TOTAL))
        next_count = CW'(TOTAL);
      else
        next_count = sum[CW-1:0];
    end
  end

  // full is derived from the next count so it always agrees with fill_count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_count <= '0;
      full       <= 1'b0;
    end else begin
      fill_count <= next_count;
      full       <= (next_count == CW'(TOTAL));
    end
  end

endmodule

// File: rtl/shift_cube.sv
// Three-dimensional shift register with bit and element shift modes.
// Optional parallel load is enabled by defining SHIFT_CUBE_LOAD_EN.
module shift_cube
  import shift_cube_pkg::*;
#(
  parameter int DA    = 3,
  parameter int DB    = 5,
  parameter int DC    = 2,
  parameter int A_LO  = 0,
  parameter int B_LO  = 0,
  parameter int C_LO  = 0,
  parameter int A_ASC = 0,
  parameter int B_ASC = 0,
  parameter int C_ASC = 0,
  localparam int TOTAL = DA * DB * DC,
  localparam int CW    = $clog2(TOTAL + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          shift_en,
  input  logic          mode,
  input  logic          in_bit,
  input  logic [DC-1:0] in_elem,
`ifdef SHIFT_CUBE_LOAD_EN
  input  logic             load,
  input  logic [TOTAL-1:0] load_data,
`endif
  output logic [(A_ASC != 0 ? A_LO : A_LO+DA-1) : (A_ASC != 0 ? A_LO+DA-1 : A_LO)]
               [(B_ASC != 0 ? B_LO : B_LO+DB-1) : (B_ASC != 0 ? B_LO+DB-1 : B_LO)]
               [(C_ASC != 0 ? C_LO : C_LO+DC-1) : (C_ASC != 0 ? C_LO+DC-1 : C_LO)] out,
  output logic          serial_out,
  output logic [CW-1:0] fill_count,
  output logic          full
);

  logic [TOTAL-1:0] cube;
  logic [TOTAL-1:0] bit_next;
  logic [TOTAL-1:0] elem_next;
  logic [TOTAL-1:0] shift_next;
  logic             load_hit;
  logic             shift_hit;
  logic [CW-1:0]    step;

  generate
    if (TOTAL > 1) begin : g_bit_wide
      assign bit_next = {cube[TOTAL-2:0], in_bit};
    end else begin : g_bit_single
      assign bit_next = in_bit;
    end
    if (TOTAL > DC) begin : g_elem_wide
      assign elem_next = {cube[TOTAL-DC-1:0], in_elem};
    end else begin : g_elem_single
      assign elem_next = in_elem;
    end
  endgenerate

  always_comb begin
    shift_next = bit_next;
    step       = CW'(1);
    if (mode_e'(mode) == MODE_ELEM) begin
      shift_next = elem_next;
      step       = CW'(DC);
    end
  end

  // Resolve priority once so the storage and the counter see the same decision.
`ifdef SHIFT_CUBE_LOAD_EN
  assign load_hit  = load & ~clear;
`else
  assign load_hit  = 1'b0;
`endif
  assign shift_hit = shift_en & ~clear & ~load_hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cube       <= '0;
      serial_out <= 1'b0;
    end else if (clear) begin
      cube       <= '0;
      serial_out <= 1'b0;
`ifdef SHIFT_CUBE_LOAD_EN
    end else if (load_hit) begin
      cube       <= load_data;
`endif
    end else if (shift_hit) begin
      cube       <= shift_next;
      serial_out <= cube[TOTAL-1];
    end
  end

  shift_cube_fill_ctr #(
    .TOTAL (TOTAL),
    .CW    (CW)
  ) u_fill_ctr (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .load       (load_hit),
    .shift      (shift_hit),
    .step       (step),
    .fill_count (fill_count),
    .full       (full)
  );

  // Map every declared (a,b,c) onto its logical position in the flat store.
  generate
    for (genvar i = 0; i < DA; i++) begin : g_a
      for (genvar j = 0; j < DB; j++) begin : g_b
        for (genvar k = 0; k < DC; k++) begin : g_c
          localparam int P = cube_pos(A_LO + i, B_LO + j, C_LO + k,
                                      A_LO, B_LO, C_LO, DB, DC);
          assign out[A_LO + i][B_LO + j][C_LO + k] = cube[P];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_shift_cube.sv
// Self-checking bench for shift_cube: a reference model feeds a scoreboard queue
// for the default instance, plus a second instance with offset/ascending ranges.
module tb_shift_cube;

  localparam int TOTAL = 30;

  typedef struct {
    logic [29:0] flat;
    logic        ser;
    int          fill;
    logic        full;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             clear, shift_en, mode, in_bit;
  logic [1:0]       in_elem;
  logic             load;
  logic [29:0]      load_data;
  logic [2:0][4:0][1:0] out;
  logic             serial_out;
  logic [4:0]       fill_count;
  logic             full;

  logic             shift2, mode2;
  logic [1:0]       elem2;
  logic [3:5][6:2][1:2] out2;
  logic             serial2;
  logic [4:0]       fill2;
  logic             full2;

  logic [29:0] m_bits;
  logic        m_ser;
  int          m_fill;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  shift_cube dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .shift_en   (shift_en),
    .mode       (mode),
    .in_bit     (in_bit),
    .in_elem    (in_elem),
`ifdef SHIFT_CUBE_LOAD_EN
    .load       (load),
    .load_data  (load_data),
`endif
    .out        (out),
    .serial_out (serial_out),
    .fill_count (fill_count),
    .full       (full)
  );

  shift_cube #(
    .DA(3), .DB(5), .DC(2), .A_LO(3), .B_LO(2), .C_LO(1),
    .A_ASC(1), .B_ASC(0), .C_ASC(1)
  ) dut2 (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (1'b0),
    .shift_en   (shift2),
    .mode       (mode2),
    .in_bit     (1'b0),
    .in_elem    (elem2),
`ifdef SHIFT_CUBE_LOAD_EN
    .load       (1'b0),
    .load_data  (30'h0),
`endif
    .out        (out2),
    .serial_out (serial2),
    .fill_count (fill2),
    .full       (full2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_bits = '0;
    m_ser  = 1'b0;
    m_fill = 0;
  endtask

  // Drive one cycle, advance the model, queue its prediction, compare after the edge.
  task automatic applyStimulus(input logic clr, input logic ld, input logic [29:0] ldd,
                               input logic sh, input logic md, input logic b,
                               input logic [1:0] e, input string tag);
    exp_t ex;
    bit   load_on;
    @(negedge clock);
    clear = clr; load = ld; load_data = ldd;
    shift_en = sh; mode = md; in_bit = b; in_elem = e;
`ifdef SHIFT_CUBE_LOAD_EN
    load_on = ld;
`else
    load_on = 1'b0;
`endif
    if (clr) begin
      modelReset();
    end else if (load_on) begin
      m_bits = ldd;
      m_fill = TOTAL;
    end else if (sh) begin
      m_ser = m_bits[TOTAL-1];
      if (md) begin
        for (int p = TOTAL - 1; p >= 2; p--) m_bits[p] = m_bits[p-2];
        m_bits[1] = e[1];
        m_bits[0] = e[0];
        m_fill = m_fill + 2;
      end else begin
        for (int p = TOTAL - 1; p >= 1; p--) m_bits[p] = m_bits[p-1];
        m_bits[0] = b;
        m_fill = m_fill + 1;
      end
      if (m_fill > TOTAL) m_fill = TOTAL;
    end
    ex.flat = m_bits;
    ex.ser  = m_ser;
    ex.fill = m_fill;
    ex.full = (m_fill == TOTAL);
    sb.push_back(ex);
    @(posedge clock);
    #1;
    ex = sb.pop_front();
    checkOutput({tag, " out"},  64'(out),        64'(ex.flat));
    checkOutput({tag, " ser"},  64'(serial_out), 64'(ex.ser));
    checkOutput({tag, " fill"}, 64'(fill_count), 64'(ex.fill));
    checkOutput({tag, " full"}, 64'(full),       64'(ex.full));
  endtask

  initial begin
    reset_n = 1'b0;
    clear = 0; shift_en = 0; mode = 0; in_bit = 0; in_elem = 0;
    load = 0; load_data = '0;
    shift2 = 0; mode2 = 0; elem2 = 0;
    modelReset();
    #3;
    checkOutput("rst out",  64'(out),        64'h0);
    checkOutput("rst ser",  64'(serial_out), 64'h0);
    checkOutput("rst fill", 64'(fill_count), 64'h0);
    checkOutput("rst full", 64'(full),       64'h0);
    checkOutput("rst fill2", 64'(fill2),     64'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Offset/ascending instance: one element shift lands in position 0..1.
    @(negedge clock);
    shift2 = 1; mode2 = 1; elem2 = 2'b10;
    @(posedge clock);
    #1;
    shift2 = 0;
    checkOutput("asc hi",   64'(out2[3][2][2]), 64'h1);
    checkOutput("asc lo",   64'(out2[3][2][1]), 64'h0);
    checkOutput("asc fill", 64'(fill2),         64'h2);
    checkOutput("asc full", 64'(full2),         64'h0);

    for (int n = 0; n < 30; n++) applyStimulus(0, 0, '0, 1, 0, 1, 2'b00, "fill1");
    applyStimulus(0, 0, '0, 1, 0, 1, 2'b00, "sat");

    applyStimulus(1, 0, '0, 0, 0, 0, 2'b00, "clear");
    applyStimulus(0, 0, '0, 1, 0, 1, 2'b00, "walk1");
    for (int n = 0; n < 29; n++) applyStimulus(0, 0, '0, 1, 0, 0, 2'b00, "walk0");
    checkOutput("corner", 64'(out[2][4][1]), 64'h1);
    applyStimulus(0, 0, '0, 1, 0, 0, 2'b00, "exit");

    // Mixed element/bit shifts and idle cycles.
    applyStimulus(1, 0, '0, 0, 0, 0, 2'b00, "clear2");
    for (int n = 0; n < 24; n++)
      applyStimulus(0, 0, '0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "mix");
    applyStimulus(0, 0, '0, 0, 1, 1, 2'b11, "hold");
    applyStimulus(1, 0, '0, 1, 1, 1, 2'b11, "clrwin");

`ifdef SHIFT_CUBE_LOAD_EN
    applyStimulus(0, 0, '0, 1, 0, 1, 2'b00, "pre");
    applyStimulus(1, 1, 30'h3FFFFFFF, 1, 0, 1, 2'b00, "prio");
    applyStimulus(0, 1, 30'h2AAAAAAA, 0, 0, 0, 2'b00, "load");
    applyStimulus(0, 1, 30'h15555555, 1, 1, 0, 2'b11, "ldwin");
    applyStimulus(0, 0, '0, 1, 0, 0, 2'b00, "postld");
`endif

    // Reset pulsed mid-cycle while a shift is requested.
    applyStimulus(0, 0, '0, 1, 1, 0, 2'b11, "prerst");
    @(negedge clock);
    shift_en = 1; mode = 0; in_bit = 1; clear = 0; load = 0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst out",  64'(out),        64'h0);
    checkOutput("arst fill", 64'(fill_count), 64'h0);
    checkOutput("arst full", 64'(full),       64'h0);
    checkOutput("arst ser",  64'(serial_out), 64'h0);
    @(posedge clock);
    #1;
    checkOutput("arst hold", 64'(out), 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    shift_en = 0;
    modelReset();
    applyStimulus(0, 0, '0, 1, 0, 1, 2'b00, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
